// File: rtl/branch_flush_ctrl.sv
// Front-end redirect arbiter: picks the oldest taken-branch source, steers the PC mux
// and holds a per-stage flush mask for FLUSH_CYCLES cycles, with younger-path squashing.
module branch_flush_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NSRC         = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NSRC-1:0]       REDIR_VALID,
  input  logic [NSRC*WIDTH-1:0] REDIR_TARGET,
  input  logic                  STALL,
  output logic [NSRC-1:0]       REDIR_ACK,
  output logic                  PC_SEL,
  output logic [WIDTH-1:0]      PC_TARGET,
  output logic [NSRC-1:0]       FLUSH,
  output logic                  BUSY,
  output logic [15:0]           REDIR_CNT
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] lidx_q, lidx_d;
  logic             pc_sel_q, pc_sel_d;
  logic [WIDTH-1:0] pc_target_q, pc_target_d;
  logic [NSRC-1:0]  flush_q, flush_d;
  logic [15:0]      redir_cnt_q, redir_cnt_d;

  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_tgt;
  logic             accept;

  // Oldest requester wins: later loop iterations override earlier ones.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_tgt   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (REDIR_VALID[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_tgt   = REDIR_TARGET[i*WIDTH +: WIDTH];
      end
    end
  end

  // A flush in progress only yields to a strictly older redirect.
  always_comb begin
    accept    = win_valid && !STALL && !RESET &&
                ((state_q == S_IDLE) || (win_idx > lidx_q));
    REDIR_ACK = '0;
    if (accept) begin
      REDIR_ACK[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lidx_d      = lidx_q;
    pc_sel_d    = 1'b0;
    pc_target_d = pc_target_q;
    flush_d     = flush_q;
    redir_cnt_d = redir_cnt_q;

    if (accept) begin
      state_d     = S_FLUSH;
      cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
      lidx_d      = win_idx;
      pc_sel_d    = 1'b1;
      pc_target_d = win_tgt;
      for (int unsigned k = 0; k < NSRC; k++) begin
        flush_d[k] = (IDX_W'(k) <= win_idx);
      end
      if (redir_cnt_q != 16'hFFFF) begin
        redir_cnt_d = redir_cnt_q + 16'd1;
      end
    end else if ((state_q == S_FLUSH) && !STALL) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        flush_d = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lidx_q      <= '0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      flush_q     <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lidx_q      <= lidx_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
      flush_q     <= flush_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign PC_SEL    = pc_sel_q;
  assign PC_TARGET = pc_target_q;
  assign FLUSH     = flush_q;
  assign BUSY      = (state_q == S_FLUSH);
  assign REDIR_CNT = redir_cnt_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Bench for branch_flush_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model; a second 8-source instance exercises counter saturation.
module tb_branch_flush_ctrl;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  valid;
  logic [63:0] target;
  logic        stall;
  logic [1:0]  ack;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic [1:0]  flush;
  logic        busy;
  logic [15:0] rcnt;

  logic         s_rst;
  logic [7:0]   s_valid;
  logic [255:0] s_target;
  logic         s_stall;
  logic [7:0]   s_ack;
  logic         s_pc_sel;
  logic [31:0]  s_pc_target;
  logic [7:0]   s_flush;
  logic         s_busy;
  logic [15:0]  s_cnt;

  branch_flush_ctrl #(.WIDTH(32), .NSRC(2), .FLUSH_CYCLES(FC)) dut (
    .CLK(clk), .RESET(rst), .REDIR_VALID(valid), .REDIR_TARGET(target), .STALL(stall),
    .REDIR_ACK(ack), .PC_SEL(pc_sel), .PC_TARGET(pc_target), .FLUSH(flush),
    .BUSY(busy), .REDIR_CNT(rcnt)
  );

  branch_flush_ctrl #(.WIDTH(32), .NSRC(8), .FLUSH_CYCLES(1)) dut_sat (
    .CLK(clk), .RESET(s_rst), .REDIR_VALID(s_valid), .REDIR_TARGET(s_target), .STALL(s_stall),
    .REDIR_ACK(s_ack), .PC_SEL(s_pc_sel), .PC_TARGET(s_pc_target), .FLUSH(s_flush),
    .BUSY(s_busy), .REDIR_CNT(s_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: busy flag, flush cycles still owed, oldest latched source.
  bit          m_busy;
  int          m_lidx;
  int          m_remain;
  bit          m_pcsel;
  logic [31:0] m_tgt;
  logic [1:0]  m_flush;
  int          m_cnt;

  function automatic logic [1:0] model_ack();
    int w;
    if (rst || stall || valid == 2'b00) return 2'b00;
    w = valid[1] ? 1 : 0;
    if (!m_busy || w > m_lidx) return 2'(1 << w);
    return 2'b00;
  endfunction

  task automatic tick();
    logic [1:0] a;
    int w;
    a = model_ack();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_lidx = 0; m_remain = 0; m_pcsel = 0;
      m_tgt = '0; m_flush = '0; m_cnt = 0;
    end else if (a != 2'b00) begin
      w        = a[1] ? 1 : 0;
      m_pcsel  = 1;
      m_tgt    = target[w*32 +: 32];
      m_flush  = 2'((1 << (w + 1)) - 1);
      m_lidx   = w;
      m_remain = FC;
      m_busy   = 1;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_pcsel = 0;
      if (m_busy && !stall) begin
        m_remain--;
        if (m_remain == 0) begin
          m_busy  = 0;
          m_flush = '0;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1,
                       input logic s);
    valid  = v;
    target = {t1, t0};
    stall  = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 32'h100, 32'h200, 1'b0);
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL reset_ack got=%b exp=00", ack); end
    tick();
    tick();
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if ({pc_sel, pc_target, flush, rcnt} !== 51'd0) begin
      fails++; $display("FAIL reset_outs got=%b/%h/%b/%h exp=all zero", pc_sel, pc_target, flush, rcnt);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    drive(2'b01, 32'h100, 32'h0, 1'b0);
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL single_ack got=%b exp=01", ack); end
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if ({pc_sel, pc_target, flush, busy} !== {1'b1, 32'h100, 2'b01, 1'b1}) begin
      fails++; $display("FAIL single_first got=%b/%h/%b/%b exp=1/100/01/1", pc_sel, pc_target, flush, busy);
    end
    tick();
    tests++; if ({pc_sel, flush, busy} !== {1'b0, 2'b01, 1'b1}) begin
      fails++; $display("FAIL single_hold got=%b/%b/%b exp=0/01/1", pc_sel, flush, busy);
    end
    tick();
    tests++; if ({flush, busy} !== {2'b00, 1'b0}) begin
      fails++; $display("FAIL single_done got=%b/%b exp=00/0", flush, busy);
    end
  endtask

  task automatic test_priority();
    rst = 1'b1; tick(); rst = 1'b0;
    drive(2'b11, 32'h100, 32'h200, 1'b0);
    tests++; if (ack !== 2'b10) begin fails++; $display("FAIL prio_ack got=%b exp=10", ack); end
    tick();
    drive(2'b01, 32'h100, 32'h0, 1'b0);
    tests++; if ({pc_sel, pc_target, flush, rcnt} !== {1'b1, 32'h200, 2'b11, 16'd1}) begin
      fails++; $display("FAIL prio_outs got=%b/%h/%b/%0d exp=1/200/11/1", pc_sel, pc_target, flush, rcnt);
    end
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL prio_wrongpath got=%b exp=00", ack); end
    tick(); tick();
    tests++; if (ack !== 2'b01) begin fails++; $display("FAIL prio_held got=%b exp=01", ack); end
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tick(); tick();
  endtask

  task automatic test_preempt();
    drive(2'b01, 32'h100, 32'h0, 1'b0);
    tick();
    drive(2'b10, 32'h0, 32'h300, 1'b0);
    tests++; if (ack !== 2'b10) begin fails++; $display("FAIL preempt_ack got=%b exp=10", ack); end
    tick();
    drive(2'b01, 32'h400, 32'h0, 1'b0);
    tests++; if ({pc_sel, pc_target, flush} !== {1'b1, 32'h300, 2'b11}) begin
      fails++; $display("FAIL preempt_outs got=%b/%h/%b exp=1/300/11", pc_sel, pc_target, flush);
    end
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL preempt_young got=%b exp=00", ack); end
    tick();
    tests++; if ({pc_sel, busy, flush} !== {1'b0, 1'b1, 2'b11}) begin
      fails++; $display("FAIL preempt_restart got=%b/%b/%b exp=0/1/11", pc_sel, busy, flush);
    end
    tick();
    tests++; if ({busy, ack} !== {1'b0, 2'b01}) begin
      fails++; $display("FAIL preempt_end got=%b/%b exp=0/01", busy, ack);
    end
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if (pc_target !== 32'h400) begin fails++; $display("FAIL preempt_late got=%h exp=400", pc_target); end
    tick(); tick();
  endtask

  task automatic test_stall();
    drive(2'b01, 32'h500, 32'h0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({pc_sel, pc_target, flush, busy} !== {1'b0, 32'h500, 2'b01, 1'b1}) begin
        fails++; $display("FAIL stall_freeze%0d got=%b/%h/%b/%b exp=0/500/01/1", i, pc_sel, pc_target, flush, busy);
      end
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    tests++; if ({flush, busy} !== {2'b00, 1'b0}) begin
      fails++; $display("FAIL stall_release got=%b/%b exp=00/0", flush, busy);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b01, 32'h600, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    drive(2'b10, 32'h0, 32'h700, 1'b0);
    tests++; if (ack !== 2'b00) begin fails++; $display("FAIL rstmid_ack got=%b exp=00", ack); end
    tick();
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    tests++; if ({pc_sel, pc_target, flush, busy, rcnt} !== 52'd0) begin
      fails++; $display("FAIL rstmid_outs got=%b/%h/%b/%b/%h exp=all zero", pc_sel, pc_target, flush, busy, rcnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_a;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!valid[i] && $urandom_range(0, 2) == 0) begin
          valid[i] = 1'b1;
          target[i*32 +: 32] = $urandom;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      #1;
      exp_a = model_ack();
      tests++; if (ack !== exp_a) begin fails++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, ack, exp_a); end
      tick();
      valid = valid & ~exp_a;
      tests++; if (pc_sel !== m_pcsel) begin fails++; $display("FAIL rand_pcsel c=%0d got=%b exp=%b", c, pc_sel, m_pcsel); end
      tests++; if (pc_target !== m_tgt) begin fails++; $display("FAIL rand_target c=%0d got=%h exp=%h", c, pc_target, m_tgt); end
      tests++; if (flush !== m_flush) begin fails++; $display("FAIL rand_flush c=%0d got=%b exp=%b", c, flush, m_flush); end
      tests++; if (busy !== m_busy) begin fails++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
      tests++; if (rcnt !== 16'(m_cnt)) begin fails++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, rcnt, m_cnt); end
    end
    rst = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  // Sources 0..7 preempt one another in turn, then one idle-return cycle.
  task automatic test_saturation();
    int n;
    int p;
    int ack_err;
    int expc;
    logic [7:0] exp_a;
    n = 0; p = 0; ack_err = 0;
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0;
    while (n < 65540) begin
      exp_a   = (p < 8) ? 8'(1 << p) : 8'h00;
      s_valid = exp_a;
      #1;
      if (s_ack !== exp_a) ack_err++;
      @(posedge clk); #1;
      if (p < 8) n++;
      p = (p == 8) ? 0 : p + 1;
      if (exp_a != 8'h00 && (n == 1 || n == 65534 || n == 65535 || n == 65536 || n == 65540)) begin
        expc = (n > 65535) ? 65535 : n;
        tests++; if (s_cnt !== 16'(expc)) begin
          fails++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, s_cnt, expc);
        end
      end
    end
    tests++; if (ack_err != 0) begin fails++; $display("FAIL sat_ack errors=%0d exp=0", ack_err); end
    tests++; if ({s_pc_sel, s_busy, s_flush, s_pc_target} !== {1'b1, 1'b1, 8'h0F, 32'h1003}) begin
      fails++; $display("FAIL sat_last got=%b/%b/%h/%h exp=1/1/0f/1003", s_pc_sel, s_busy, s_flush, s_pc_target);
    end
    s_valid = 8'h00;
  endtask

  initial begin
    rst = 1'b1; valid = '0; target = '0; stall = 1'b0;
    s_rst = 1'b1; s_valid = '0; s_stall = 1'b0; s_target = '0;
    for (int i = 0; i < 8; i++) s_target[i*32 +: 32] = 32'h1000 + 32'(i);
    m_busy = 0; m_lidx = 0; m_remain = 0; m_pcsel = 0; m_tgt = '0; m_flush = '0; m_cnt = 0;
    test_reset();
    test_single();
    test_priority();
    test_preempt();
    test_stall();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning redirect target width.
REQ-002 SHALL have parameter NSRC, default 2, meaning number of redirect sources; source i sits in front-end stage i+1, and a higher index is an older instruction.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning flush hold length in cycles (>=1).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port REDIR_VALID  input  NSRC  per-source branch-taken/jump request.
REQ-007 SHALL have port REDIR_TARGET  input  NSRC*WIDTH  per-source target; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port STALL  input  1  pipeline freeze.
REQ-009 SHALL have port REDIR_ACK  output  NSRC  combinational one-hot accept of the winning source.
REQ-010 SHALL have port PC_SEL  output  1  registered one-cycle pulse selecting PC_TARGET into the PC mux.
REQ-011 SHALL have port PC_TARGET  output  WIDTH  registered target of the last accepted redirect.
REQ-012 SHALL have port FLUSH  output  NSRC  registered per-stage flush; bit k clears front-end stage k.
REQ-013 SHALL have port BUSY  output  1  high while in state FLUSH.
REQ-014 SHALL have port REDIR_CNT  output  16  saturating count of accepted redirects.

Function
REQ-015 SHALL implement two states: IDLE and FLUSH, plus a down-counter CNT of width clog2(FLUSH_CYCLES+1).
REQ-016 SHALL define the winner as the highest index i with REDIR_VALID[i]=1.
REQ-017 SHALL accept the winner when STALL=0 and either (state=IDLE) or (state=FLUSH and winner index > latched index LIDX); otherwise REDIR_ACK=0.
REQ-018 SHALL drive REDIR_ACK as one-hot on the winner in the accepting cycle only; a source that is not acknowledged holds its request until acknowledged.
REQ-019 SHALL, on acceptance at edge N, present at edge N+1: PC_SEL=1 for exactly one cycle, PC_TARGET=winner target, FLUSH=mask with bits [0..i] set and others 0, LIDX=i, CNT=FLUSH_CYCLES-1, state=FLUSH.
REQ-020 SHALL, in FLUSH with STALL=0 and no acceptance, hold FLUSH and decrement CNT, and return to IDLE with FLUSH=0 at the edge where CNT=0.
REQ-021 SHALL, in FLUSH with STALL=1, freeze CNT, FLUSH, PC_TARGET and state, with PC_SEL=0.
REQ-022 SHALL treat a redirect during FLUSH with index <= LIDX as wrong-path: it is ignored and not acknowledged.
REQ-023 SHALL, on a preempting acceptance in FLUSH, relatch as in REQ-019 (restart CNT, widen mask, new pulse).
REQ-024 SHALL, when multiple sources are valid in the same cycle, accept only the winner; lower sources see no ACK.
REQ-025 SHALL increment REDIR_CNT by 1 per acceptance and saturate at 16'hFFFF.
REQ-026 SHALL, with FLUSH_CYCLES=1, return to IDLE one cycle after the PC_SEL cycle unless preempted.

Reset
REQ-027 SHALL, with RESET=1 at an edge, force state=IDLE, CNT=0, LIDX=0, PC_SEL=0, PC_TARGET=0, FLUSH=0, REDIR_CNT=0, regardless of any in-progress flush.
REQ-028 SHALL drive REDIR_ACK=0 while RESET=1, and accept nothing in a reset cycle.

Verification (WIDTH=32, NSRC=2, FLUSH_CYCLES=2)
REQ-029 SHALL cover: VALID=01, target0=0x100, STALL=0 -> ACK=01; next cycle PC_SEL=1, PC_TARGET=0x100, FLUSH=01, BUSY=1; FLUSH=01 for 2 cycles, then IDLE with FLUSH=00.
REQ-030 SHALL cover: VALID=11, targets 0x100/0x200 -> ACK=10, PC_TARGET=0x200, FLUSH=11, REDIR_CNT=1.
REQ-031 SHALL cover: a source-0 redirect being flushed, source 1 valid (0x300) in the first FLUSH cycle -> ACK=10, a second PC_SEL pulse, PC_TARGET=0x300, FLUSH=11, CNT restarted; a later source-0 request during that flush -> ACK=00.
REQ-032 SHALL cover: STALL=1 for 3 cycles mid-FLUSH -> outputs frozen, PC_SEL=0; after release, exactly 1 remaining FLUSH cycle, then IDLE.
REQ-033 SHALL cover: RESET=1 during FLUSH -> next edge all outputs 0, BUSY=0, REDIR_CNT=0.
REQ-034 SHALL cover: 65540 back-to-back accepted redirects -> REDIR_CNT=16'hFFFF.
